// File: rtl/pc_fetch.sv
// Program-counter stage: holds the PC, issues fetch requests with valid/ready and selects PC+4 or
// the redirect target. Optional macro PC_MISALIGN_TRAP_EN sends misaligned targets to TRAP_VECTOR.
module pc_fetch #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        pc_src_i,
   input  logic [31:0] target_i,
   input  logic        stall_i,
   input  logic        fetch_ready_i,
   output logic        fetch_valid_o,
   output logic [31:0] pc_o,
   output logic [31:0] pc_plus4_o,
   output logic [31:0] fetch_count_o,
   output logic        misalign_o
);

   typedef enum logic [1:0] {StIdle, StFetch, StHold} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] count_q, count_d;
   logic        misalign_q, misalign_d;
   logic        handshake;
   logic [31:0] redirect_pc;
   logic        redirect_misalign;

`ifdef PC_MISALIGN_TRAP_EN
   assign redirect_misalign = |target_i[1:0];
   assign redirect_pc       = redirect_misalign ? TRAP_VECTOR : target_i;
`else
   logic [33:0] unused_trap;
   assign unused_trap       = {TRAP_VECTOR, target_i[1:0]};
   assign redirect_misalign = 1'b0;
   assign redirect_pc       = {target_i[31:2], 2'b00};
`endif

   assign fetch_valid_o = (state_q == StFetch);
   assign pc_o          = pc_q;
   assign pc_plus4_o    = pc_q + 32'd4;
   assign fetch_count_o = count_q;
   assign misalign_o    = misalign_q;
   assign handshake     = fetch_valid_o & fetch_ready_i;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      count_d    = count_q;
      misalign_d = 1'b0;

      // A redirect coinciding with acceptance still counts the accepted fetch.
      if (handshake) begin
         count_d = count_q + 32'd1;
      end

      if (pc_src_i) begin
         pc_d       = redirect_pc;
         misalign_d = redirect_misalign;
      end else if (handshake) begin
         pc_d = pc_plus4_o;
      end

      unique case (state_q)
         StIdle, StHold: begin
            state_d = stall_i ? StHold : StFetch;
         end
         StFetch: begin
            // Stall cannot withdraw an outstanding request.
            if (pc_src_i || handshake) begin
               state_d = stall_i ? StHold : StFetch;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         pc_q       <= RESET_PC;
         count_q    <= 32'd0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         count_q    <= count_d;
         misalign_q <= misalign_d;
      end
   end

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: per-scenario tasks push expected post-edge state to a
// scoreboard queue and pop/compare it once the DUT has updated.
module tb_pc_fetch;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        pc_src_i;
   logic [31:0] target_i;
   logic        stall_i;
   logic        fetch_ready_i;
   logic        fetch_valid_o;
   logic [31:0] pc_o;
   logic [31:0] pc_plus4_o;
   logic [31:0] fetch_count_o;
   logic        misalign_o;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic        rst_n;
      logic        src;
      logic [31:0] tgt;
      logic        stall;
      logic        rdy;
   } stim_t;

   typedef struct packed {
      logic [31:0] pc;
      logic        valid;
      logic [31:0] cnt;
      logic        mis;
   } exp_t;

   exp_t exp_q[$];

`ifdef PC_MISALIGN_TRAP_EN
   localparam logic [31:0] PC49  = 32'h0000_0100;
   localparam logic        MIS49 = 1'b1;
`else
   localparam logic [31:0] PC49  = 32'h0000_0030;
   localparam logic        MIS49 = 1'b0;
`endif

   pc_fetch dut (
      .clk_i        (clk),
      .rst_ni       (rst_ni),
      .pc_src_i     (pc_src_i),
      .target_i     (target_i),
      .stall_i      (stall_i),
      .fetch_ready_i(fetch_ready_i),
      .fetch_valid_o(fetch_valid_o),
      .pc_o         (pc_o),
      .pc_plus4_o   (pc_plus4_o),
      .fetch_count_o(fetch_count_o),
      .misalign_o   (misalign_o)
   );

   always #5 clk = ~clk;

   function automatic stim_t st(logic rst_n, logic src, logic [31:0] tgt, logic stall, logic rdy);
      st = '{rst_n: rst_n, src: src, tgt: tgt, stall: stall, rdy: rdy};
   endfunction

   function automatic exp_t ex(logic [31:0] pc, logic valid, logic [31:0] cnt, logic mis);
      ex = '{pc: pc, valid: valid, cnt: cnt, mis: mis};
   endfunction

   // Apply one cycle of stimulus; returns 1 ns after the rising edge.
   task automatic drive(input stim_t s);
      rst_ni        = s.rst_n;
      pc_src_i      = s.src;
      target_i      = s.tgt;
      stall_i       = s.stall;
      fetch_ready_i = s.rdy;
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t observed();
      observed = '{pc: pc_o, valid: fetch_valid_o, cnt: fetch_count_o, mis: misalign_o};
   endfunction

   // Leaves the DUT in FETCH at pc 0 with a zero count.
   task automatic do_reset();
      drive(st(1'b0, 1'b0, 32'h0, 1'b0, 1'b0));
      drive(st(1'b0, 1'b0, 32'h0, 1'b0, 1'b0));
      drive(st(1'b1, 1'b0, 32'h0, 1'b0, 1'b0));
   endtask

   task automatic test_reset();
      stim_t s[4];
      exp_t  e[4];
      exp_t  got, want;
      s[0] = st(1'b0, 1'b0, 32'h0, 1'b0, 1'b1); e[0] = ex(32'h0, 1'b0, 32'd0, 1'b0);
      s[1] = st(1'b0, 1'b1, 32'h44, 1'b0, 1'b1); e[1] = ex(32'h0, 1'b0, 32'd0, 1'b0);
      s[2] = st(1'b1, 1'b0, 32'h0, 1'b0, 1'b0); e[2] = ex(32'h0, 1'b1, 32'd0, 1'b0);
      s[3] = st(1'b1, 1'b0, 32'h0, 1'b0, 1'b0); e[3] = ex(32'h0, 1'b1, 32'd0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         // Check the IDLE bubble right after the reset edges, before rst_ni rises.
         if (i == 2) begin
            total++;
            if (fetch_valid_o !== 1'b0) begin
               bad++;
               $display("FAIL reset_bubble valid=%b expected 0", fetch_valid_o);
            end
         end
         exp_q.push_back(e[i]);
         drive(s[i]);
         got  = observed();
         want = exp_q.pop_front();
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL reset[%0d] got pc=%h v=%b cnt=%0d mis=%b expected pc=%h v=%b cnt=%0d mis=%b",
                     i, got.pc, got.valid, got.cnt, got.mis, want.pc, want.valid, want.cnt, want.mis);
         end
      end
   endtask

   task automatic test_sequential();
      stim_t s[4];
      exp_t  e[4];
      exp_t  got, want;
      do_reset();
      s[0] = st(1'b1, 1'b0, 32'h0, 1'b0, 1'b1); e[0] = ex(32'h4, 1'b1, 32'd1, 1'b0);
      s[1] = st(1'b1, 1'b0, 32'h0, 1'b0, 1'b1); e[1] = ex(32'h8, 1'b1, 32'd2, 1'b0);
      s[2] = st(1'b1, 1'b0, 32'h0, 1'b0, 1'b1); e[2] = ex(32'hC, 1'b1, 32'd3, 1'b0);
      s[3] = st(1'b1, 1'b0, 32'h0, 1'b1, 1'b0); e[3] = ex(32'hC, 1'b1, 32'd3, 1'b0);
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(e[i]);
         drive(s[i]);
         got  = observed();
         want = exp_q.pop_front();
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL seq[%0d] got pc=%h v=%b cnt=%0d mis=%b expected pc=%h v=%b cnt=%0d mis=%b",
                     i, got.pc, got.valid, got.cnt, got.mis, want.pc, want.valid, want.cnt, want.mis);
         end
      end
      total++;
      if (pc_plus4_o !== 32'h10) begin
         bad++;
         $display("FAIL pc_plus4 got %h expected 00000010", pc_plus4_o);
      end
   endtask

   task automatic test_redirect_wrap();
      stim_t s[5];
      exp_t  e[5];
      exp_t  got, want;
      do_reset();
      s[0] = st(1'b1, 1'b1, 32'd49, 1'b0, 1'b0);        e[0] = ex(PC49, 1'b1, 32'd0, MIS49);
      s[1] = st(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);         e[1] = ex(PC49, 1'b1, 32'd0, 1'b0);
      s[2] = st(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0); e[2] = ex(32'hFFFF_FFFC, 1'b1, 32'd0, 1'b0);
      s[3] = st(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);         e[3] = ex(32'h0, 1'b1, 32'd1, 1'b0);
      s[4] = st(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);         e[4] = ex(32'h4, 1'b1, 32'd2, 1'b0);
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(e[i]);
         drive(s[i]);
         got  = observed();
         want = exp_q.pop_front();
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL redir[%0d] got pc=%h v=%b cnt=%0d mis=%b expected pc=%h v=%b cnt=%0d mis=%b",
                     i, got.pc, got.valid, got.cnt, got.mis, want.pc, want.valid, want.cnt, want.mis);
         end
      end
   endtask

   task automatic test_stall();
      stim_t s[7];
      exp_t  e[7];
      exp_t  got, want;
      do_reset();
      s[0] = st(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);  e[0] = ex(32'h4, 1'b1, 32'd1, 1'b0);
      s[1] = st(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);  e[1] = ex(32'h4, 1'b1, 32'd1, 1'b0);
      s[2] = st(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);  e[2] = ex(32'h8, 1'b1, 32'd2, 1'b0);
      s[3] = st(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);  e[3] = ex(32'hC, 1'b0, 32'd3, 1'b0);
      s[4] = st(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);  e[4] = ex(32'hC, 1'b0, 32'd3, 1'b0);
      s[5] = st(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);  e[5] = ex(32'hC, 1'b1, 32'd3, 1'b0);
      s[6] = st(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);  e[6] = ex(32'hC, 1'b1, 32'd3, 1'b0);
      for (int i = 0; i < 7; i++) begin
         exp_q.push_back(e[i]);
         drive(s[i]);
         got  = observed();
         want = exp_q.pop_front();
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL stall[%0d] got pc=%h v=%b cnt=%0d mis=%b expected pc=%h v=%b cnt=%0d mis=%b",
                     i, got.pc, got.valid, got.cnt, got.mis, want.pc, want.valid, want.cnt, want.mis);
         end
      end
   endtask

   task automatic test_back_to_back();
      stim_t s[6];
      exp_t  e[6];
      exp_t  got, want;
      do_reset();
      s[0] = st(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);   e[0] = ex(32'h4, 1'b1, 32'd1, 1'b0);
      s[1] = st(1'b1, 1'b1, 32'h40, 1'b0, 1'b1);  e[1] = ex(32'h40, 1'b1, 32'd2, 1'b0);
      s[2] = st(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);   e[2] = ex(32'h44, 1'b0, 32'd3, 1'b0);
      s[3] = st(1'b1, 1'b1, 32'h80, 1'b1, 1'b1);  e[3] = ex(32'h80, 1'b0, 32'd3, 1'b0);
      s[4] = st(1'b1, 1'b1, 32'h84, 1'b0, 1'b0);  e[4] = ex(32'h84, 1'b1, 32'd3, 1'b0);
      s[5] = st(1'b1, 1'b1, 32'h90, 1'b0, 1'b0);  e[5] = ex(32'h90, 1'b1, 32'd3, 1'b0);
      for (int i = 0; i < 6; i++) begin
         exp_q.push_back(e[i]);
         drive(s[i]);
         got  = observed();
         want = exp_q.pop_front();
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL b2b[%0d] got pc=%h v=%b cnt=%0d mis=%b expected pc=%h v=%b cnt=%0d mis=%b",
                     i, got.pc, got.valid, got.cnt, got.mis, want.pc, want.valid, want.cnt, want.mis);
         end
      end
   endtask

   task automatic test_reset_mid();
      stim_t s[4];
      exp_t  e[4];
      exp_t  got, want;
      do_reset();
      s[0] = st(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);   e[0] = ex(32'h4, 1'b1, 32'd1, 1'b0);
      s[1] = st(1'b0, 1'b1, 32'h3, 1'b0, 1'b1);   e[1] = ex(32'h0, 1'b0, 32'd0, 1'b0);
      s[2] = st(1'b1, 1'b1, 32'h20, 1'b0, 1'b1);  e[2] = ex(32'h20, 1'b1, 32'd0, 1'b0);
      s[3] = st(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);   e[3] = ex(32'h24, 1'b1, 32'd1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(e[i]);
         drive(s[i]);
         got  = observed();
         want = exp_q.pop_front();
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL rstmid[%0d] got pc=%h v=%b cnt=%0d mis=%b expected pc=%h v=%b cnt=%0d mis=%b",
                     i, got.pc, got.valid, got.cnt, got.mis, want.pc, want.valid, want.cnt, want.mis);
         end
      end
   endtask

   initial begin
      rst_ni        = 1'b0;
      pc_src_i      = 1'b0;
      target_i      = 32'h0;
      stall_i       = 1'b0;
      fetch_ready_i = 1'b0;
      test_reset();
      test_sequential();
      test_redirect_wrap();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain left=%0d expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Program-counter stage for the RV32I core: holds the architectural PC, issues fetch requests to instruction memory with a valid/ready handshake, and selects the next PC from either sequential PC+4 or the branch/jump target. The target comes from the downstream pc_target adder. pc_o drives both pc_target's pc_i and the instruction-memory address, and pc_target's instruction_o returns here as target_i. The block also counts accepted fetches and optionally traps misaligned targets.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- TRAP_VECTOR, 32'h0000_0100, redirect address for misaligned targets (used only with PC_MISALIGN_TRAP_EN)
- clk_i  input  1  clock; all state updates on rising edge
- rst_ni  input  1  synchronous, active-low reset
- pc_src_i  input  1  1 = redirect to target_i this cycle
- target_i  input  32  branch/jump target (pc_target instruction_o)
- stall_i  input  1  pipeline stall request
- fetch_ready_i  input  1  instruction memory accepts the request
- fetch_valid_o  output  1  fetch request valid; address is pc_o
- pc_o  output  32  current PC (registered)
- pc_plus4_o  output  32  pc_o + 4, combinational, mod 2^32
- fetch_count_o  output  32  number of accepted fetches, wraps at 2^32
- misalign_o  output  1  one-cycle pulse after a misaligned redirect

## Operation
- States:
  - IDLE: post-reset bubble.
  - FETCH: request outstanding.
  - HOLD: stalled.
- fetch_valid_o = (state == FETCH); it is a Moore output with no combinational path from inputs.
- Handshake: the fetch is accepted when fetch_valid_o && fetch_ready_i.
- Once fetch_valid_o is asserted, pc_o stays stable until acceptance or redirect. stall_i never drops fetch_valid_o mid-request.
- Per-cycle priority: reset > redirect > handshake > stall.
- Reset (rst_ni=0 at edge): pc_o=RESET_PC, state=IDLE, fetch_valid_o=0, fetch_count_o=0, misalign_o=0.
- IDLE:
  - goes to FETCH next cycle if stall_i=0, otherwise to HOLD.
  - A redirect in IDLE loads the PC and follows the same state rule.
- FETCH:
  - Redirect: pc_o <= target_i (see Configuration). State goes to HOLD if stall_i, else stays FETCH. If a handshake occurs the same cycle, fetch_count_o still increments.
  - Handshake without redirect: pc_o <= pc_plus4_o and fetch_count_o++. Next state is HOLD if stall_i, else FETCH.
  - No handshake: pc_o is held, state stays FETCH, and stall_i is ignored.
- HOLD:
  - fetch_valid_o=0 and fetch_ready_i is ignored.
  - Goes to FETCH when stall_i=0.
  - A redirect loads the PC; state goes to FETCH if stall_i=0, else stays HOLD.
- Arithmetic: all PC math is 32-bit unsigned, mod 2^32. For example, 0xFFFF_FFFC + 4 = 0x0000_0000. target_i is taken as given, already wrapped by the adder.

## Timing
- pc_o, fetch_valid_o, fetch_count_o and misalign_o are all registered and update one cycle after the causing edge.
- Redirect latency: pc_src_i sampled at edge N gives the new pc_o visible after edge N.
- The first fetch request appears in the second cycle after rst_ni rises, because of the IDLE bubble.
- Sequential throughput: one fetch per cycle while fetch_ready_i=1 and stall_i=0.
- Reset mid-request aborts the request: fetch_valid_o=0 on the next cycle and the count is not incremented.

## Configuration
- PC_MISALIGN_TRAP_EN defined:
  - A redirect with target_i[1:0] != 0 loads pc_o <= TRAP_VECTOR.
  - misalign_o is asserted for exactly the one cycle following the redirect edge.
  - Aligned targets load unchanged.
- PC_MISALIGN_TRAP_EN not defined:
  - Redirect loads {target_i[31:2], 2'b00}.
  - misalign_o is tied to 0 and TRAP_VECTOR is unused.

## Test plan
- Reset: rst_ni=0 for 2 cycles, then 1 → pc_o=0, fetch_valid_o=0 during reset and during the first cycle after; fetch_valid_o=1 with pc_o=0 in the second cycle.
- Sequential run: fetch_ready_i=1 for 3 cycles → pc_o goes 0, 4, 8, 0xC; fetch_count_o=3.
- Redirect to 49 (the pc_target result of 16+33): with the macro → pc_o=0x100 and misalign_o=1 for one cycle. Without the macro → pc_o=0x30 and misalign_o=0.
- Wrap: redirect to 0xFFFF_FFFC, then a handshake → pc_o=0x0000_0000 and fetch_count_o increments.
- Stall: at pc_o=8, fetch_ready_i=1 and stall_i=1 → pc_o=0xC and fetch_valid_o=0 while stall_i=1 (fetch_ready_i ignored); stall_i=0 → fetch_valid_o=1 next cycle at pc_o=0xC.
- Redirect with handshake in the same cycle, target 0x40 at pc_o=4 → pc_o=0x40 (not 8); fetch_count_o increments.
